// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter that time-shares one 16-bit double-dabble binary-to-BCD
// converter among NUM_REQ requesters. One conversion is in flight at a time.
module bcd_convert_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_bin,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [19:0]             rsp_bcd,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StConv,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] id_q;
    logic [15:0]     op_q;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    int unsigned     cand;
    logic [ID_W-1:0] cand_idx;

    // Converter state
    logic [15:0]     sh_q;
    logic [19:0]     bcd_q;
    logic [4:0]      cnt_q;
    logic [19:0]     bcd_adj;
    logic            conv_load;
    logic            conv_done;

    // Pick the first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // FSM next state and accept strobe; req_ready only ever high in IDLE.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    state_d              = StLoad;
                end
            end
            StLoad: state_d = StConv;
            StConv: begin
                if (conv_done) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, round-robin pointer and grant-cycle operand capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && grant_found) begin
                op_q <= req_bin[16*grant_idx +: 16];
                id_q <= grant_idx;
            end
            if (state_q == StResp && rsp_ready) begin
                rr_ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    // Double-dabble add-3 correction on every BCD digit before the shift.
    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < 5; k++) begin
            bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                          : bcd_q[4*k +: 4];
        end
    end

    assign conv_load = reset || (state_q == StLoad);
    assign conv_done = (cnt_q == 5'd16);

    // Converter: reload on its reset, then one shift per cycle for 16 cycles and hold.
    always_ff @(posedge clock) begin
        if (conv_load) begin
            sh_q  <= reset ? 16'd0 : op_q;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (!conv_done) begin
            bcd_q <= {bcd_adj[18:0], sh_q[15]};
            sh_q  <= {sh_q[14:0], 1'b0};
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_bcd   = bcd_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/bcd_convert_arbiter.md
BCD_CONVERT_ARBITER -- requirements
Module: bcd_convert_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-002 Localparam ID_W = $clog2(NUM_REQ).
REQ-003 clock  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester conversion request.
REQ-006 req_bin  input  16*NUM_REQ  operands; requester i occupies bits [16*i+15:16*i].
REQ-007 req_ready  output  NUM_REQ  one-hot accept strobe; at most one bit high per cycle.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_bcd  output  20  five packed BCD digits; digit k at bits [4k+3:4k].
REQ-011 rsp_id  output  ID_W  index of the requester that owns rsp_bcd.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 Block SHALL own one 16-bit double-dabble converter instance (WIDTH_IN=16), time-shared among all requesters.
- Converter reset input = reset OR (state==LOAD).
REQ-014 FSM states SHALL be IDLE, LOAD, CONV, RESP.
REQ-015 IDLE: if any req_valid bit is high, grant the first requester at or after rr_ptr (wrapping modulo NUM_REQ).
- Assert that requester's req_ready for exactly this cycle.
- Latch its req_bin and index.
- Go to LOAD.
- No req_valid high: stay in IDLE, req_ready = 0.
REQ-016 req_ready SHALL be 0 in LOAD, CONV and RESP; req_ready SHALL depend combinationally on req_valid only while in IDLE.
REQ-017 LOAD: lasts exactly one cycle; the converter loads the latched operand; go to CONV.
REQ-018 CONV: stay until converter done is sampled high, then go to RESP.
- done is 0 in the first CONV cycle, because the converter is already reloaded.
REQ-019 RESP: rsp_valid = 1; rsp_bcd = converter bcd output; rsp_id = latched index.
- rsp_bcd and rsp_id SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-020 RESP with rsp_ready=1: go to IDLE; rr_ptr <= (granted index + 1) mod NUM_REQ.
REQ-021 Latency, with the accept cycle = T: LOAD at T+1, CONV T+2..T+18, first rsp_valid at T+19, regardless of operand value.
REQ-022 Earliest next accept is the cycle after the rsp handshake; a single conversion is in flight at a time; no queuing.
REQ-023 Requesters SHALL hold req_valid and req_bin until their req_ready; the block SHALL NOT sample req_bin in any cycle other than the grant cycle.
REQ-024 A requester deasserting req_valid before being granted is not served and gets no response.
REQ-025 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,...,NUM_REQ-1,0,...
REQ-026 rsp_bcd SHALL equal the decimal value of the granted operand, 0..65535 -> 20'h00000..20'h65535.

Reset
REQ-027 reset=1 SHALL, at the next edge, force state=IDLE, rr_ptr=0, rsp_valid=0, req_ready=0, busy=0, rsp_id=0, and clear the latched operand.
REQ-028 reset asserted during LOAD, CONV or RESP SHALL abort the conversion; no rsp_valid for the aborted request.
REQ-029 The first grant after reset SHALL go to the lowest-indexed valid requester.
REQ-030 req_ready SHALL be 0 in any cycle where reset=1.

Verification
REQ-031 Only req_valid[2]=1, bin=12345, rsp_ready=1 -> req_ready=4'b0100 at T; rsp_valid at T+19, rsp_bcd=20'h12345, rsp_id=2.
REQ-032 All four valid, operands 0, 9999, 65535, 100 -> grant order 0,1,2,3; responses 20'h00000, 20'h09999, 20'h65535, 20'h00100 with matching rsp_id.
REQ-033 rsp_ready held low 10 cycles in RESP -> rsp_valid, rsp_bcd and rsp_id stable; req_ready stays 0 for every requester throughout.
REQ-034 reset pulsed at T+8 of a conversion -> no response; busy=0 next cycle; a new request to requester 3 is then served with the correct value.
REQ-035 req_valid[1] drops before its grant while req_valid[0] is served -> no response tagged id 1; rr_ptr=1 next selects the next valid requester at or after index 1.
